// File: rtl/paillier_lite_sequencer.sv
// AXI-Lite master that drives a Paillier accelerator: writes block count and
// control, polls status until done, and repeats for TEST_TIMES runs.
module paillier_lite_sequencer #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [1:0]            MODE        = 2'b00,
    parameter int unsigned           BLOCK_COUNT = 1,
    parameter int unsigned           TEST_TIMES  = 1,
    parameter int unsigned           POLL_GAP    = 16,
    parameter int unsigned           POLL_LIMIT  = 65535
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESETN,
    input  logic                    INIT_AXI_TXN,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERROR,
    output logic [7:0]              RUN_CNT,
    output logic [ADDR_WIDTH-1:0]   AWADDR,
    output logic [2:0]              AWPROT,
    output logic                    AWVALID,
    input  logic                    AWREADY,
    output logic [DATA_WIDTH-1:0]   WDATA,
    output logic [DATA_WIDTH/8-1:0] WSTRB,
    output logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    output logic                    BREADY,
    output logic [ADDR_WIDTH-1:0]   ARADDR,
    output logic [2:0]              ARPROT,
    output logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    output logic                    RREADY
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0] ADDR_BLKCNT = BASE_ADDR + ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = BASE_ADDR + ADDR_WIDTH'(8);
    localparam logic [DATA_WIDTH-1:0] DATA_BLKCNT = DATA_WIDTH'(BLOCK_COUNT);
    localparam logic [DATA_WIDTH-1:0] DATA_CTRL   = DATA_WIDTH'({MODE, 1'b1});
    localparam logic [7:0]            RUNS        = 8'(TEST_TIMES);

    typedef enum logic [2:0] {
        IDLE,
        WR_BLK,
        WR_CTRL,
        POLL_WAIT,
        RD_STAT,
        NEXT,
        FIN,
        ERR
    } state_t;

    state_t      state;
    logic        init_q;
    logic        aw_done;
    logic        w_done;
    logic [31:0] gap_cnt;
    logic [31:0] poll_cnt;

    logic        start;
    logic        aw_hs;
    logic        w_hs;
    logic [31:0] poll_next;
    logic [7:0]  run_next;
    logic        unused_rdata;

    assign AWPROT = 3'b000;
    assign ARPROT = 3'b000;
    assign WSTRB  = '1;

    assign start     = INIT_AXI_TXN & ~init_q & (state == IDLE || state == FIN || state == ERR);
    assign aw_hs     = AWVALID & AWREADY;
    assign w_hs      = WVALID & WREADY;
    assign poll_next = poll_cnt + 32'd1;
    assign run_next  = (RUN_CNT == 8'hFF) ? 8'hFF : RUN_CNT + 8'd1;

    // Only the done flag of the status word matters to the sequencer.
    assign unused_rdata = ^RDATA[DATA_WIDTH-1:1];

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESETN) begin
        if (M_AXI_ARESETN) begin
            state    <= IDLE;
            init_q   <= 1'b0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            gap_cnt  <= '0;
            poll_cnt <= '0;
            AWADDR   <= '0;
            AWVALID  <= 1'b0;
            WDATA    <= '0;
            WVALID   <= 1'b0;
            BREADY   <= 1'b0;
            ARADDR   <= '0;
            ARVALID  <= 1'b0;
            RREADY   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERROR    <= 1'b0;
            RUN_CNT  <= '0;
        end else begin
            init_q <= INIT_AXI_TXN;
            case (state)
                IDLE, FIN, ERR: begin
                    if (start) begin
                        BUSY     <= 1'b1;
                        DONE     <= 1'b0;
                        ERROR    <= 1'b0;
                        RUN_CNT  <= '0;
                        poll_cnt <= '0;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
                        AWADDR   <= ADDR_BLKCNT;
                        WDATA    <= DATA_BLKCNT;
                        AWVALID  <= 1'b1;
                        WVALID   <= 1'b1;
                        state    <= WR_BLK;
                    end
                end

                // AW and W complete independently; the response is only
                // accepted once both address and data have been taken.
                WR_BLK, WR_CTRL: begin
                    if (BREADY) begin
                        if (BVALID) begin
                            BREADY  <= 1'b0;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            if (BRESP != 2'b00) begin
                                ERROR <= 1'b1;
                                BUSY  <= 1'b0;
                                state <= ERR;
                            end else if (state == WR_BLK) begin
                                AWADDR  <= ADDR_CTRL;
                                WDATA   <= DATA_CTRL;
                                AWVALID <= 1'b1;
                                WVALID  <= 1'b1;
                                state   <= WR_CTRL;
                            end else begin
                                gap_cnt <= '0;
                                state   <= POLL_WAIT;
                            end
                        end
                    end else begin
                        if (aw_hs) begin
                            AWVALID <= 1'b0;
                            aw_done <= 1'b1;
                        end
                        if (w_hs) begin
                            WVALID <= 1'b0;
                            w_done <= 1'b1;
                        end
                        if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                            BREADY <= 1'b1;
                        end
                    end
                end

                POLL_WAIT: begin
                    if (gap_cnt + 32'd1 >= POLL_GAP) begin
                        ARADDR  <= ADDR_STATUS;
                        ARVALID <= 1'b1;
                        state   <= RD_STAT;
                    end else begin
                        gap_cnt <= gap_cnt + 32'd1;
                    end
                end

                RD_STAT: begin
                    if (ARVALID && ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                    end
                    if (RREADY && RVALID) begin
                        RREADY <= 1'b0;
                        if (RRESP != 2'b00) begin
                            ERROR <= 1'b1;
                            BUSY  <= 1'b0;
                            state <= ERR;
                        end else if (RDATA[0]) begin
                            state <= NEXT;
                        end else begin
                            poll_cnt <= poll_next;
                            if (poll_next >= POLL_LIMIT) begin
                                ERROR <= 1'b1;
                                BUSY  <= 1'b0;
                                state <= ERR;
                            end else begin
                                gap_cnt <= '0;
                                state   <= POLL_WAIT;
                            end
                        end
                    end
                end

                NEXT: begin
                    RUN_CNT  <= run_next;
                    poll_cnt <= '0;
                    if (run_next == RUNS) begin
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= FIN;
                    end else begin
                        AWADDR  <= ADDR_BLKCNT;
                        WDATA   <= DATA_BLKCNT;
                        AWVALID <= 1'b1;
                        WVALID  <= 1'b1;
                        state   <= WR_BLK;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_paillier_lite_sequencer.sv
// Directed bench for paillier_lite_sequencer with a behavioural AXI-Lite slave
// whose ready/response timing and status behaviour are set per test.
module tb_paillier_lite_sequencer;

    localparam logic [31:0] CTRL_ADDR = 32'h0000_0100;
    localparam logic [31:0] BLK_ADDR  = 32'h0000_0104;
    localparam logic [31:0] STAT_ADDR = 32'h0000_0108;
    localparam logic [31:0] BLK_DATA  = 32'd3;
    localparam logic [31:0] CTRL_DATA = 32'd3;
    localparam int          GAP       = 4;
    localparam logic [31:0] NO_ERR    = 32'hFFFF_FFFF;

    logic        clk;
    logic        rst;
    logic        init;
    logic        BUSY, DONE, ERROR;
    logic [7:0]  RUN_CNT;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          aw_delay, w_delay, b_delay, done_on;
    logic [31:0] err_addr;
    logic [1:0]  err_resp;
    logic        aw_got, w_got, ar_got;
    int          aw_cnt, w_cnt, b_cnt;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    int          wr_n, rd_n, reads_in_run, viol, bad_araddr, last_ar, min_gap;

    paillier_lite_sequencer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h100), .MODE(2'b01),
        .BLOCK_COUNT(3), .TEST_TIMES(2), .POLL_GAP(GAP), .POLL_LIMIT(4)
    ) dut (
        .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst), .INIT_AXI_TXN(init),
        .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR), .RUN_CNT(RUN_CNT),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clearLog();
        wr_n = 0; rd_n = 0; reads_in_run = 0; viol = 0; bad_araddr = 0;
        last_ar = -1; min_gap = 1000000;
    endtask

    task automatic applyStimulus(input int don, input int awd, input int wd, input int bd,
                                 input logic [31:0] ea, input logic [1:0] er);
        done_on = don; aw_delay = awd; w_delay = wd; b_delay = bd;
        err_addr = ea; err_resp = er;
        clearLog();
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
    endtask

    task automatic waitIdle(input string tag);
        int n = 0;
        while (BUSY && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_finished"}, 32'(BUSY), 32'd0);
    endtask

    // Slave acts on falling edges so every handshake lands on the next rising edge.
    initial begin : slave
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
        ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
        aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
                aw_got = 0; w_got = 0; ar_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
            end else begin
                if ((AWVALID || WVALID) && ARVALID) viol++;
                if (BVALID) begin
                    BVALID = 0;
                    if (wr_n < 16) begin
                        wr_addr[wr_n] = cap_awaddr;
                        wr_data[wr_n] = cap_wdata;
                    end
                    wr_n++;
                    if (cap_awaddr == BLK_ADDR) reads_in_run = 0;
                    aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                end
                if (AWREADY) begin
                    AWREADY = 0; aw_got = 1;
                    if (AWVALID) viol++;
                end else if (AWVALID && !aw_got) begin
                    if (aw_cnt >= aw_delay) begin AWREADY = 1; cap_awaddr = AWADDR; end
                    else aw_cnt++;
                end
                if (WREADY) begin
                    WREADY = 0; w_got = 1;
                    if (WVALID) viol++;
                end else if (WVALID && !w_got) begin
                    if (w_cnt >= w_delay) begin WREADY = 1; cap_wdata = WDATA; end
                    else w_cnt++;
                end
                if (aw_got && !w_got && (AWVALID || !WVALID)) viol++;
                if (w_got && !aw_got && (WVALID || !AWVALID)) viol++;
                if (aw_got && w_got && !BVALID) begin
                    if (!BREADY) viol++;
                    else if (b_cnt >= b_delay) begin
                        BVALID = 1;
                        BRESP = (cap_awaddr == err_addr) ? err_resp : 2'b00;
                    end else b_cnt++;
                end
                if (RVALID) begin
                    RVALID = 0; ar_got = 0;
                end
                if (ARREADY) begin
                    ARREADY = 0; ar_got = 1; rd_n++; reads_in_run++;
                    if (ARVALID) viol++;
                    if (cap_araddr != STAT_ADDR) bad_araddr++;
                    if (last_ar >= 0 && cyc - last_ar < min_gap) min_gap = cyc - last_ar;
                    last_ar = cyc;
                end else if (ARVALID && !ar_got) begin
                    ARREADY = 1; cap_araddr = ARADDR;
                end
                if (ar_got && RREADY && !RVALID) begin
                    RVALID = 1; RRESP = 2'b00;
                    RDATA = (done_on != 0 && reads_in_run >= done_on) ? 32'h8000_0001 : 32'hFFFF_FFFE;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        rst = 1'b1; init = 1'b0;
        done_on = 1; aw_delay = 0; w_delay = 0; b_delay = 0;
        err_addr = NO_ERR; err_resp = 2'b00;
        clearLog();
        repeat (3) @(negedge clk);
        checkOutput("rst_busy",    32'(BUSY),    32'd0);
        checkOutput("rst_done",    32'(DONE),    32'd0);
        checkOutput("rst_error",   32'(ERROR),   32'd0);
        checkOutput("rst_run_cnt", 32'(RUN_CNT), 32'd0);
        checkOutput("rst_valids",  32'({AWVALID, WVALID, BREADY, ARVALID, RREADY}), 32'd0);
        checkOutput("rst_awaddr",  AWADDR, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] normal run: done on second status read, retrigger while busy");
        applyStimulus(2, 0, 0, 0, NO_ERR, 2'b00);
        checkOutput("t1_busy_start", 32'(BUSY), 32'd1);
        repeat (6) @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        waitIdle("t1");
        checkOutput("t1_done",     32'(DONE),    32'd1);
        checkOutput("t1_error",    32'(ERROR),   32'd0);
        checkOutput("t1_run_cnt",  32'(RUN_CNT), 32'd2);
        checkOutput("t1_writes",   32'(wr_n),    32'd4);
        checkOutput("t1_reads",    32'(rd_n),    32'd4);
        checkOutput("t1_wr0_addr", wr_addr[0],   BLK_ADDR);
        checkOutput("t1_wr0_data", wr_data[0],   BLK_DATA);
        checkOutput("t1_wr1_addr", wr_addr[1],   CTRL_ADDR);
        checkOutput("t1_wr1_data", wr_data[1],   CTRL_DATA);
        checkOutput("t1_wr3_addr", wr_addr[3],   CTRL_ADDR);
        checkOutput("t1_araddr",   32'(bad_araddr), 32'd0);
        checkOutput("t1_protocol", 32'(viol),    32'd0);

        $display("[TB] slow write: WREADY 5 cycles after AWREADY, BVALID 3 cycles later");
        applyStimulus(1, 0, 5, 3, NO_ERR, 2'b00);
        waitIdle("t2");
        checkOutput("t2_done",     32'(DONE),    32'd1);
        checkOutput("t2_run_cnt",  32'(RUN_CNT), 32'd2);
        checkOutput("t2_writes",   32'(wr_n),    32'd4);
        checkOutput("t2_reads",    32'(rd_n),    32'd2);
        checkOutput("t2_wr2_data", wr_data[2],   BLK_DATA);
        checkOutput("t2_protocol", 32'(viol),    32'd0);

        $display("[TB] SLVERR on control write");
        applyStimulus(1, 0, 0, 0, CTRL_ADDR, 2'b10);
        waitIdle("t3");
        checkOutput("t3_error",   32'(ERROR),   32'd1);
        checkOutput("t3_done",    32'(DONE),    32'd0);
        checkOutput("t3_reads",   32'(rd_n),    32'd0);
        checkOutput("t3_writes",  32'(wr_n),    32'd2);
        checkOutput("t3_run_cnt", 32'(RUN_CNT), 32'd0);

        $display("[TB] status never done: poll limit");
        applyStimulus(0, 0, 0, 0, NO_ERR, 2'b00);
        waitIdle("t4");
        checkOutput("t4_error",        32'(ERROR),   32'd1);
        checkOutput("t4_done",         32'(DONE),    32'd0);
        checkOutput("t4_reads",        32'(rd_n),    32'd4);
        checkOutput("t4_poll_spacing", 32'(min_gap), 32'(GAP + 2));
        checkOutput("t4_protocol",     32'(viol),    32'd0);

        $display("[TB] reset during held write address");
        applyStimulus(1, 20, 0, 0, NO_ERR, 2'b00);
        repeat (3) @(negedge clk);
        checkOutput("t5_aw_held", 32'(AWVALID), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("t5_rst_awvalid", 32'(AWVALID), 32'd0);
        checkOutput("t5_rst_wvalid",  32'(WVALID),  32'd0);
        checkOutput("t5_rst_busy",    32'(BUSY),    32'd0);
        checkOutput("t5_rst_awaddr",  AWADDR,       32'd0);
        checkOutput("t5_rst_wdata",   WDATA,        32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("t5_stays_idle", 32'(BUSY), 32'd0);
        checkOutput("t5_no_writes",  32'(wr_n), 32'd0);
        applyStimulus(1, 0, 0, 0, NO_ERR, 2'b00);
        waitIdle("t5");
        checkOutput("t5_done",    32'(DONE),    32'd1);
        checkOutput("t5_run_cnt", 32'(RUN_CNT), 32'd2);
        checkOutput("t5_writes",  32'(wr_n),    32'd4);
        checkOutput("t5_reads",   32'(rd_n),    32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/paillier_lite_sequencer.md
PAILLIER_LITE_SEQUENCER -- requirements
Module: paillier_lite_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI-Lite data width (32 or 64).
REQ-003 SHALL have parameter BASE_ADDR, default 0, slave register base.
REQ-004 SHALL have parameter MODE, default 2'b00: encryption=00, decryption=01, homomorphic add=10, scalar mul=11.
REQ-005 SHALL have parameter BLOCK_COUNT, default 1, value written to the block-count register.
REQ-006 SHALL have parameter TEST_TIMES, default 1, runs per trigger (1..255).
REQ-007 SHALL have parameter POLL_GAP, default 16, idle cycles between status reads.
REQ-008 SHALL have parameter POLL_LIMIT, default 65535, max status reads per run.
REQ-009 SHALL have ports: M_AXI_ACLK in 1 clock; M_AXI_ARESETN in 1, reset M_AXI_ARESETN, asynchronous, active-high.
REQ-010 SHALL have ports: INIT_AXI_TXN in 1 trigger; BUSY out 1; DONE out 1 sticky; ERROR out 1 sticky; RUN_CNT out 8 completed runs.
REQ-011 SHALL have write ports: AWADDR out ADDR_WIDTH, AWPROT out 3 (fixed 0), AWVALID out, AWREADY in, WDATA out DATA_WIDTH, WSTRB out DATA_WIDTH/8 (all ones), WVALID out, WREADY in, BRESP in 2, BVALID in, BREADY out.
REQ-012 SHALL have read ports: ARADDR out ADDR_WIDTH, ARPROT out 3 (fixed 0), ARVALID out, ARREADY in, RDATA in DATA_WIDTH, RRESP in 2, RVALID in, RREADY out.

Function
REQ-013 SHALL use register map: BASE+0x00 CTRL (bit0 start, bits2:1 mode), BASE+0x04 BLKCNT, BASE+0x08 STATUS (bit0 done).
REQ-014 SHALL run FSM IDLE -> WR_BLK -> WR_CTRL -> POLL_WAIT -> RD_STAT -> (POLL_WAIT | NEXT) -> WR_BLK or FIN; any failure -> ERR.
REQ-015 SHALL start on a rising edge of INIT_AXI_TXN (registered edge detect) only in IDLE, FIN or ERR; edges while BUSY ignored.
REQ-016 SHALL on start clear DONE, ERROR, RUN_CNT and the poll counter in the same cycle BUSY rises.
REQ-017 SHALL in WR_BLK/WR_CTRL assert AWVALID and WVALID in the same cycle; each held with stable addr/data until its own handshake; each dropped independently on handshake.
REQ-018 SHALL assert BREADY after both AW and W handshakes; hold until BVALID; BRESP != 00 -> ERR.
REQ-019 SHALL write WDATA = BLOCK_COUNT in WR_BLK and {MODE,1'b1} zero-extended in WR_CTRL.
REQ-020 SHALL in POLL_WAIT count POLL_GAP cycles, then enter RD_STAT.
REQ-021 SHALL in RD_STAT hold ARVALID with ARADDR=BASE+0x08 until ARREADY, then RREADY=1 until RVALID.
REQ-022 SHALL on R handshake: RRESP != 00 -> ERR; RDATA[0]=1 -> NEXT; else increment poll counter, ERR if it reaches POLL_LIMIT, otherwise POLL_WAIT.
REQ-023 SHALL in NEXT increment RUN_CNT (saturating at 255), reset poll counter; RUN_CNT==TEST_TIMES -> FIN else WR_BLK.
REQ-024 SHALL in FIN set DONE=1, BUSY=0; in ERR set ERROR=1, BUSY=0; both return to IDLE behaviour for new triggers.
REQ-025 SHALL keep BUSY=1 from start cycle until FIN/ERR entry; never issue AR and AW concurrently.
REQ-026 SHALL tolerate AWREADY/WREADY/ARREADY high before VALID (no combinational VALID-on-READY dependency).

Reset
REQ-027 SHALL on M_AXI_ARESETN=1 immediately force FSM=IDLE, all VALID/READY outputs 0, BUSY=0, DONE=0, ERROR=0, RUN_CNT=0, addresses/data 0, edge detector cleared.
REQ-028 SHALL, on reset mid-transaction, abandon the transaction without completing it and require a fresh INIT_AXI_TXN edge after release.

Verification
REQ-029 SHALL: MODE=01, BLOCK_COUNT=3, TEST_TIMES=1, slave returns done on 2nd read -> writes 0x04<=3, 0x00<=0x3, two reads of 0x08, DONE=1, RUN_CNT=1, ERROR=0.
REQ-030 SHALL: TEST_TIMES=4, done on first read each run -> exactly 8 writes, 4 reads, RUN_CNT=4, DONE=1.
REQ-031 SHALL: WREADY 5 cycles after AWREADY, BVALID 3 cycles later -> AWVALID drops at AW handshake, WVALID held to its own, BREADY held until BVALID, single write per register.
REQ-032 SHALL: BRESP=10 on CTRL write -> ERROR=1, DONE=0, BUSY=0, no AR issued.
REQ-033 SHALL: POLL_LIMIT=4, status never done -> 4 reads spaced POLL_GAP+ cycles, then ERROR=1.
REQ-034 SHALL: reset asserted with AWVALID=1 mid-run -> AWVALID=0 same cycle asynchronously, all outputs at reset values; second INIT_AXI_TXN while BUSY ignored.
